mem_io_bridge: RTL and testbench
================================

# mem_io_bridge

Memory-mapped bus bridge sitting directly downstream of the single-cycle CPU core's memory port. Consumes the core's ALU result as address, `rf_rd2` as store data and the core's write strobe. Routes each access either to the data RAM or to on-board peripherals (LEDs, switches, buttons, 8-digit seven-segment display, cycle counter). Returns read data combinationally, so loads complete in the same cycle as the core requires.

## Interface
Parameters:
- `SCAN_DIV`, 20000: clock cycles each display digit stays enabled.
- `DRAM_AW`, 14: DRAM word-address width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  system clock.
  - `rst`  in  1  asynchronous reset, active-high.
- CPU side:
  - `cpu_addr`  in  32  byte address (core `alu_c`).
  - `cpu_wdata`  in  32  store data (core `rf_rd2`).
  - `cpu_we`  in  1  store strobe (core `dram_we`).
  - `cpu_rdata`  out  32  load data (to core `dram_rd`).
- DRAM side:
  - `dram_addr`  out  DRAM_AW  word address, `cpu_addr[DRAM_AW+1:2]`.
  - `dram_wdata`  out  32  equal to `cpu_wdata`.
  - `dram_we`  out  1  DRAM write enable.
  - `dram_rdata`  in  32  DRAM read data.
- Board side:
  - `sw`  in  24  switches, asynchronous.
  - `btn`  in  5  buttons, asynchronous.
  - `led`  out  24  LED drive, active-high.
  - `dig_en`  out  8  digit enables, active-low.
  - `dig_seg`  out  8  {DP,G,F,E,D,C,B,A}, active-low.

## Operation
Address decode uses `cpu_addr`; bits [1:0] are ignored.
- `addr < 0xFFFF_F000`: DRAM access.
  - `dram_we = cpu_we`.
  - `cpu_rdata = dram_rdata`.
- `0xFFFF_F000`: DIG register (R/W, 32 bits). Holds 8 hex nibbles; nibble i drives digit i.
- `0xFFFF_F060`: LED register (R/W).
  - Writes store `cpu_wdata[23:0]`.
  - Reads return zero-extended value.
- `0xFFFF_F070`: switches (RO). Returns synchronized `sw`, zero-extended.
- `0xFFFF_F078`: buttons (RO). Returns synchronized `btn`, zero-extended.
- `0xFFFF_F080`: CYCLE counter (RO).
  - 32-bit, increments every clock.
  - Wraps 0xFFFF_FFFF→0.
- Any other `0xFFFF_Fxxx` address:
  - Reads return 0.
  - Writes are ignored.
- Writes to RO registers are ignored.
- `dram_we` is 0 for every IO address.
- Display scan:
  - Counter runs 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances mod 8 (7→0).
  - Registered outputs each cycle: `dig_en = ~(1<<idx)`, `dig_seg = seg(DIG[4*idx+3:4*idx])`.
  - DP always off. Hex A–F use standard patterns (e.g. 0→0xC0, 1→0xF9, 8→0x80, F→0x8E).

## Timing
- Reads are combinational from `cpu_addr` to `cpu_rdata`, zero cycles.
- Register writes commit on the rising edge where `cpu_we=1`. Readback and `led` reflect the new value from the next cycle.
- `sw`/`btn` pass through a two-flop synchronizer. A change appears on `cpu_rdata` after 2 rising edges.
- `dig_en`/`dig_seg` lag the index/DIG state by 1 cycle.
- Reset values, applied asynchronously:
  - `led=0`, DIG=0, CYCLE=0.
  - Synchronizers 0, scan counter 0, idx 0.
  - `dig_en=0xFF`, `dig_seg=0xFF` (all off).
- First edge after reset release: `dig_en=0xFE`, `dig_seg=0xC0`.
- CYCLE read in the first cycle after reset release is 0. It is N after N edges.
- Store and CYCLE increment in the same cycle: the store is ignored and the increment proceeds.
- DIG write during a scan: the new nibble appears at the next output register update, with no scan reset.
- Reset mid-scan: all state returns to reset values immediately.

## Structure
- Package `io_map_pkg` holds:
  - address constants `ADDR_DIG`, `ADDR_LED`, `ADDR_SW`, `ADDR_BTN`, `ADDR_CYCLE`, `IO_BASE`;
  - the 16-entry hex-to-segment constant function.
- Sub-module `seg7_scan` contains the scan counter, digit index and registered `dig_en`/`dig_seg`. It takes DIG as a 32-bit input.
- The top contains decode, registers, synchronizers, CYCLE and the read mux.

## Test plan
- DRAM path: store 0x1234_5678 at 0x0000_0010 → `dram_we=1`, `dram_addr=4`. Load with `dram_rdata=0xCAFE0000` → `cpu_rdata=0xCAFE0000`.
- LED: store 0xFFAB_CDEF to 0xFFFF_F060 → next cycle `led=0xABCDEF`, readback 0x00AB_CDEF, `dram_we=0` throughout.
- Switch sync: set `sw=0x00F00F` → readback at 0xFFFF_F070 is old value after 1 edge and 0x0000_F00F after 2 edges.
- Scan with `SCAN_DIV=4`: DIG=0x7654_3210 → `dig_en` steps FE,FD,…,7F,FE every 4 cycles, `dig_seg` 0xC0 then 0xF9…
- CYCLE: read 0 right after reset, 10 after 10 edges. A store to 0xFFFF_F080 is ignored. Preload via force to 0xFFFF_FFFF → 0 next cycle.
- Async reset mid-operation: assert `rst` between edges with LED=0xFF → `led=0`, `dig_en=0xFF` immediately without clock.

Source files
------------

// File: rtl/io_map_pkg.sv
// io_map_pkg: shared address map, access-select type and seven-segment
// decode for the memory-mapped IO bridge.
//   io_decode()  : word address (byte address bits [31:2]) -> io_sel_t
//   hex_to_seg() : hex nibble -> active-low {DP,G,F,E,D,C,B,A}, DP off
package io_map_pkg;

    localparam logic [31:0] IO_BASE    = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_DIG   = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_LED   = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW    = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN   = 32'hFFFF_F078;
    localparam logic [31:0] ADDR_CYCLE = 32'hFFFF_F080;

    typedef enum logic [2:0] {
        SEL_DRAM,
        SEL_DIG,
        SEL_LED,
        SEL_SW,
        SEL_BTN,
        SEL_CYCLE,
        SEL_NONE
    } io_sel_t;

    // Byte-lane bits are dropped before decode, so every comparison is on words.
    function automatic io_sel_t io_decode(input logic [29:0] wa);
        io_sel_t sel;
        if (wa < IO_BASE[31:2])              sel = SEL_DRAM;
        else if (wa == ADDR_DIG[31:2])       sel = SEL_DIG;
        else if (wa == ADDR_LED[31:2])       sel = SEL_LED;
        else if (wa == ADDR_SW[31:2])        sel = SEL_SW;
        else if (wa == ADDR_BTN[31:2])       sel = SEL_BTN;
        else if (wa == ADDR_CYCLE[31:2])     sel = SEL_CYCLE;
        else                                 sel = SEL_NONE;
        return sel;
    endfunction

    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for an 8-digit seven-segment display.
// Each digit is enabled for SCAN_DIV clocks; outputs are registered and lag
// the digit index / DIG contents by one cycle.
//   clk, rst : clock, asynchronous active-high reset
//   dig      : 8 hex nibbles, nibble i shown on digit i
//   dig_en   : digit enables, active-low
//   dig_seg  : {DP,G,F,E,D,C,B,A}, active-low
module seg7_scan
    import io_map_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dig,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] scan_cnt;
    logic [2:0]    idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            dig_en   <= '1;
            dig_seg  <= '1;
        end else begin
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + CW'(1);
            end
            dig_en  <= ~(8'd1 << idx);
            dig_seg <= hex_to_seg(dig[{idx, 2'b00} +: 4]);
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: routes the single-cycle core's memory port to data RAM or
// to board peripherals. Loads are combinational; stores commit on the edge.
//   clk, rst         : clock, asynchronous active-high reset
//   cpu_addr/wdata/we: core byte address, store data, store strobe
//   cpu_rdata        : load data back to the core
//   dram_addr/wdata/we, dram_rdata : data RAM port (word addressed)
//   sw, btn          : asynchronous board inputs (two-flop synchronized)
//   led              : LED drive, active-high
//   dig_en, dig_seg  : seven-segment display, active-low
module mem_io_bridge
    import io_map_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 20000,
    parameter int unsigned DRAM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    input  logic               cpu_we,
    output logic [31:0]        cpu_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic [31:0]        dram_wdata,
    output logic               dram_we,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         dig_seg
);

    io_sel_t     sel;
    logic [31:0] dig_reg;
    logic [23:0] led_reg;
    logic [31:0] cycle_cnt;
    logic [23:0] sw_s1, sw_s2;
    logic [4:0]  btn_s1, btn_s2;
    logic        addr_lsb_unused;

    assign addr_lsb_unused = ^cpu_addr[1:0];
    assign sel             = io_decode(cpu_addr[31:2]);

    assign dram_addr  = cpu_addr[DRAM_AW+1:2];
    assign dram_wdata = cpu_wdata;
    assign dram_we    = cpu_we && (sel == SEL_DRAM);
    assign led        = led_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_reg   <= '0;
            led_reg   <= '0;
            cycle_cnt <= '0;
            sw_s1     <= '0;
            sw_s2     <= '0;
            btn_s1    <= '0;
            btn_s2    <= '0;
        end else begin
            sw_s1     <= sw;
            sw_s2     <= sw_s1;
            btn_s1    <= btn;
            btn_s2    <= btn_s1;
            // CYCLE is read-only: a store to it never disturbs the increment.
            cycle_cnt <= cycle_cnt + 32'd1;
            if (cpu_we && sel == SEL_DIG) dig_reg <= cpu_wdata;
            if (cpu_we && sel == SEL_LED) led_reg <= cpu_wdata[23:0];
        end
    end

    always_comb begin
        cpu_rdata = '0;
        case (sel)
            SEL_DRAM:  cpu_rdata = dram_rdata;
            SEL_DIG:   cpu_rdata = dig_reg;
            SEL_LED:   cpu_rdata = {8'd0, led_reg};
            SEL_SW:    cpu_rdata = {8'd0, sw_s2};
            SEL_BTN:   cpu_rdata = {27'd0, btn_s2};
            SEL_CYCLE: cpu_rdata = cycle_cnt;
            default:   cpu_rdata = '0;
        endcase
    end

    seg7_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .dig    (dig_reg),
        .dig_en (dig_en),
        .dig_seg(dig_seg)
    );

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: directed sequences plus randomized accesses.
// Expected responses are queued at issue time and checked by a monitor.
module tb_mem_io_bridge;

    localparam int unsigned D = 4;

    localparam logic [31:0] A_DIG   = 32'hFFFF_F000;
    localparam logic [31:0] A_LED   = 32'hFFFF_F060;
    localparam logic [31:0] A_SW    = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN   = 32'hFFFF_F078;
    localparam logic [31:0] A_CYC   = 32'hFFFF_F080;
    localparam logic [31:0] A_IOLO  = 32'hFFFF_F000;

    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dram_wdata, dram_rdata;
    logic        cpu_we, dram_we;
    logic [13:0] dram_addr;
    logic [23:0] sw, led;
    logic [4:0]  btn;
    logic [7:0]  dig_en, dig_seg;

    always #5 clk = ~clk;

    mem_io_bridge #(
        .SCAN_DIV(D),
        .DRAM_AW (14)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .dram_addr (dram_addr),
        .dram_wdata(dram_wdata),
        .dram_we   (dram_we),
        .dram_rdata(dram_rdata),
        .sw        (sw),
        .btn       (btn),
        .led       (led),
        .dig_en    (dig_en),
        .dig_seg   (dig_seg)
    );

    // ---------------- reference model ----------------
    int          edges;
    logic [31:0] cyc_base;
    logic [23:0] m_led;
    logic [31:0] m_dig;
    logic [23:0] swh  [int];
    logic [4:0]  btnh [int];
    logic [31:0] digh [int];

    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            digh[edges + 1] = m_dig;
            swh[edges + 1]  = sw;
            btnh[edges + 1] = btn;
            if (cpu_we && same_word(cpu_addr, A_LED)) m_led = cpu_wdata[23:0];
            if (cpu_we && same_word(cpu_addr, A_DIG)) m_dig = cpu_wdata;
            edges = edges + 1;
        end
    end

    task automatic model_reset();
        edges    = 0;
        cyc_base = 32'd0;
        m_led    = '0;
        m_dig    = '0;
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a < A_IOLO && !same_word(a, A_IOLO)) return dram_rdata;
        if (same_word(a, A_DIG)) return m_dig;
        if (same_word(a, A_LED)) return {8'd0, m_led};
        if (same_word(a, A_SW))  return (edges >= 2) ? {8'd0, swh[edges - 1]} : 32'd0;
        if (same_word(a, A_BTN)) return (edges >= 2) ? {27'd0, btnh[edges - 1]} : 32'd0;
        if (same_word(a, A_CYC)) return cyc_base + 32'(edges);
        return 32'd0;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        dwe;
        logic [13:0] daddr;
        logic [31:0] dwd;
        logic [23:0] led;
        logic [7:0]  en;
        logic [7:0]  seg;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push_exp(input string tag);
        exp_t e;
        int   ix;
        e.tag   = tag;
        e.rdata = exp_read(cpu_addr);
        e.dwe   = cpu_we && (cpu_addr < A_IOLO);
        e.daddr = cpu_addr[15:2];
        e.dwd   = cpu_wdata;
        e.led   = m_led;
        if (edges == 0) begin
            e.en  = 8'hFF;
            e.seg = 8'hFF;
        end else begin
            ix    = ((edges - 1) / D) % 8;
            e.en  = ~(8'd1 << ix);
            e.seg = SEG_TAB[digh[edges][4*ix +: 4]];
        end
        sbq.push_back(e);
    endtask

    task automatic chk(input string tag, input string f, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s: got %h want %h (t=%0t)", tag, f, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk(e.tag, "cpu_rdata",  cpu_rdata,          e.rdata);
            chk(e.tag, "dram_we",    {31'd0, dram_we},   {31'd0, e.dwe});
            chk(e.tag, "dram_addr",  {18'd0, dram_addr}, {18'd0, e.daddr});
            chk(e.tag, "dram_wdata", dram_wdata,         e.dwd);
            chk(e.tag, "led",        {8'd0, led},        {8'd0, e.led});
            chk(e.tag, "dig_en",     {24'd0, dig_en},    {24'd0, e.en});
            chk(e.tag, "dig_seg",    {24'd0, dig_seg},   {24'd0, e.seg});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic we,
                         input logic [31:0] rd, input string tag);
        @(negedge clk);
        cpu_addr   = a;
        cpu_wdata  = w;
        cpu_we     = we;
        dram_rdata = rd;
        push_exp(tag);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0, 1:    a = $urandom & 32'h0000_FFFF;
            2:       a = 32'hFFFF_EFFC;
            3:       a = A_DIG;
            4:       a = A_LED;
            5:       a = A_SW;
            6:       a = A_BTN;
            7:       a = A_CYC;
            8:       a = 32'hFFFF_F064;
            default: a = 32'hFFFF_FFFC;
        endcase
        return {a[31:2], 2'(($urandom_range(0, 3)))};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        cpu_addr   = A_CYC;
        cpu_wdata  = '0;
        cpu_we     = 1'b0;
        dram_rdata = '0;
        sw         = '0;
        btn        = '0;
        model_reset();

        repeat (2) @(negedge clk);
        push_exp("reset");

        @(negedge clk);
        rst      = 1'b0;
        cpu_addr = A_CYC;
        push_exp("cycle0");
        repeat (10) drive(A_CYC, 32'd0, 1'b0, 32'd0, "cycle_count");

        drive(32'h0000_0010, 32'h1234_5678, 1'b1, 32'd0, "dram_store");
        drive(32'h0000_0010, 32'd0, 1'b0, 32'hCAFE_0000, "dram_load");
        drive(32'hFFFF_EFFF, 32'hA5A5_A5A5, 1'b1, 32'h0BAD_F00D, "dram_top");

        drive(A_LED, 32'hFFAB_CDEF, 1'b1, 32'd0, "led_store");
        drive(A_LED, 32'd0, 1'b0, 32'd0, "led_read");

        drive(A_SW, 32'd0, 1'b0, 32'd0, "sw_prev");
        sw  = 24'h00F00F;
        btn = 5'h15;
        repeat (3) drive(A_SW, 32'd0, 1'b0, 32'd0, "sw_sync");
        drive(A_BTN, 32'd0, 1'b0, 32'd0, "btn_sync");

        drive(A_CYC, 32'h0000_0123, 1'b1, 32'd0, "cycle_store");
        drive(A_CYC, 32'd0, 1'b0, 32'd0, "cycle_after_store");
        drive(A_SW, 32'hFFFF_FFFF, 1'b1, 32'd0, "sw_store");
        drive(32'hFFFF_F004, 32'hDEAD_BEEF, 1'b1, 32'd0, "unmapped_store");
        drive(32'hFFFF_F004, 32'd0, 1'b0, 32'd0, "unmapped_read");

        drive(A_DIG, 32'h7654_3210, 1'b1, 32'd0, "dig_store");
        repeat (40) drive(A_DIG, 32'd0, 1'b0, 32'd0, "scan");
        drive(A_DIG, 32'hFEDC_BA98, 1'b1, 32'd0, "dig_midscan");
        repeat (20) drive(A_DIG, 32'd0, 1'b0, 32'd0, "scan2");

        repeat (250) begin
            if ($urandom_range(0, 7) == 0) sw  = 24'($urandom);
            if ($urandom_range(0, 7) == 0) btn = 5'($urandom);
            drive(rand_addr(), $urandom, 1'($urandom_range(0, 1)), $urandom, "random");
        end

        // Preload CYCLE to all-ones and confirm the wrap to zero.
        @(negedge clk);
        cpu_addr = A_CYC;
        cpu_we   = 1'b0;
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        cyc_base = 32'hFFFF_FFFF - 32'(edges);
        push_exp("cycle_max");
        drive(A_CYC, 32'd0, 1'b0, 32'd0, "cycle_wrap");
        drive(A_CYC, 32'd0, 1'b0, 32'd0, "cycle_after_wrap");

        drive(A_LED, 32'h0000_00FF, 1'b1, 32'd0, "led_ff");
        repeat (5) drive(A_LED, 32'd0, 1'b0, 32'd0, "led_hold");
        @(negedge clk);
        rst    = 1'b1;
        cpu_we = 1'b0;
        model_reset();
        cpu_addr = A_LED;
        push_exp("async_reset");
        drive(A_CYC, 32'd0, 1'b0, 32'd0, "reset_held");
        @(negedge clk);
        rst = 1'b0;
        push_exp("reset_release");
        repeat (6) drive(A_CYC, 32'd0, 1'b0, 32'd0, "post_reset");

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
